// File: rtl/module_display_scan_ctrl.sv
// rtl/module_display_scan_ctrl.sv - binary-to-BCD sequencing and 2-digit 7-seg scan controller
// Optional leading-zero blanking of the tens digit: define LEADING_ZERO_BLANK_EN.
module module_display_scan_ctrl #(
  parameter int WIDTH       = 4,
  parameter int CONV_LAT    = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] bin_i,
  input  logic             bin_valid_i,
  output logic             bin_ready_o,
  output logic [WIDTH-1:0] conv_bin_o,
  input  logic [7:0]       conv_bcd_i,
  output logic [3:0]       digit_o,
  output logic [1:0]       anodo_o
);

  localparam int RW = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
  localparam int CW = (CONV_LAT < 1) ? 1 : $clog2(CONV_LAT + 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [7:0]      disp;
  logic [RW-1:0]   refresh_cnt;
  logic            sel;
  logic            blank;

  // Conversion sequencing: launch operand, sit out the converter pipeline, capture result.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      bin_ready_o <= 1'b1;
      conv_bin_o  <= '0;
      disp        <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bin_valid_i && bin_ready_o) begin
            conv_bin_o  <= bin_i;
            wait_cnt    <= '0;
            bin_ready_o <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == CW'(CONV_LAT)) begin
            disp        <= conv_bcd_i;
            bin_ready_o <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign blank = BLANK_EN && sel && (disp[7:4] == 4'd0);

  // Free-running digit scan; outputs lag sel/disp by one register stage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      refresh_cnt <= '0;
      sel         <= 1'b0;
      anodo_o     <= 2'b11;
      digit_o     <= 4'd0;
    end else begin
      if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        sel         <= ~sel;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (blank) begin
        anodo_o <= 2'b11;
        digit_o <= 4'd0;
      end else if (sel) begin
        anodo_o <= 2'b01;
        digit_o <= disp[7:4];
      end else begin
        anodo_o <= 2'b10;
        digit_o <= disp[3:0];
      end
    end
  end

endmodule
